food_eat_ctrl: RTL
==================

FOOD_EAT_CTRL -- requirements
Module: food_eat_ctrl

Interface
REQ-001 The block SHALL have parameter BOX_SIZE, default 10, meaning the box edge length in pixels.
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 200, meaning the move ticks before an uneaten box is relocated; used only with FOOD_TIMEOUT_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port move_tick, input, 1 bit: one-cycle strobe; head position is valid in this cycle.
REQ-006 The block SHALL have port game_active, input, 1 bit: high while the game runs.
REQ-007 The block SHALL have ports head_x (input, 10 bits) and head_y (input, 9 bits): snake head pixel position.
REQ-008 The block SHALL have ports box_x (input, 10 bits) and box_y (input, 9 bits): top-left corner of the current food box.
REQ-009 The block SHALL have port create_new_box, output, 1 bit: one-cycle request to the box generator to relocate the box.
REQ-010 The block SHALL have port grow, output, 1 bit: one-cycle request to the snake body to lengthen by one segment.
REQ-011 The block SHALL have port score_bcd, output, 8 bits: two BCD digits, tens in [7:4] and units in [3:0].
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 A hit SHALL be defined as box_x <= head_x < box_x+BOX_SIZE and box_y <= head_y < box_y+BOX_SIZE, with both sums computed one bit wider so they cannot wrap.
REQ-014 The FSM SHALL have states IDLE, EAT, TOUT, WAIT1 and WAIT2, and all outputs SHALL be registered.
REQ-015 In IDLE, when move_tick, game_active and a hit are all true, the next state SHALL be EAT.
REQ-016 In EAT, create_new_box and grow SHALL be 1 for exactly that cycle, score_bcd SHALL increment on the same edge, and the next state SHALL be WAIT1; latency is 1 cycle from the move_tick cycle to the pulses.
REQ-017 From WAIT1 the FSM SHALL go to WAIT2 and then to IDLE, covering the generator's two-cycle x/y placement; move_tick SHALL be ignored in WAIT1 and WAIT2.
REQ-018 score_bcd SHALL count 00..99 in BCD, carry units 9 into tens, and saturate at 99 (a hit at 99 still pulses create_new_box and grow).
REQ-019 When game_active is low, the FSM SHALL go to IDLE on the next edge from any state, with no pulses, and score_bcd SHALL be held.
REQ-020 A hit coincident with a timeout expiry SHALL be treated as a hit only, and the timer SHALL clear.

Reset
REQ-021 On rst, the FSM SHALL enter IDLE, and create_new_box, grow and busy SHALL be 0, score_bcd SHALL be 8'h00 and the timer SHALL be 0, at the next clk edge.
REQ-022 A rst asserted mid-sequence (EAT, TOUT, WAITn) SHALL abort the sequence without completing any pending pulse.

Configuration
REQ-023 With macro FOOD_TIMEOUT_EN defined, a counter SHALL count move_ticks in IDLE while game_active is high.
REQ-024 With FOOD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_TICKS without a hit, the FSM SHALL enter TOUT, which pulses create_new_box only (no grow, no score change) for one cycle, then go to WAIT1.
REQ-025 With FOOD_TIMEOUT_EN defined, the counter SHALL clear on a hit, on a timeout, and while game_active is low.
REQ-026 Without FOOD_TIMEOUT_EN, the counter and the TOUT state SHALL be absent, and the box SHALL move only on a hit.

Structure
REQ-027 Shared package snake_pkg SHALL hold the coordinate widths X_W=10 and Y_W=9, the BOX_SIZE default and the FSM state typedef.
REQ-028 Two-digit saturating BCD counting SHALL be implemented in sub-module bcd_counter2, with inputs clk, rst and inc, and output q[7:0].

Verification
REQ-029 Bench: box (300,300), head (305,305), move_tick -> create_new_box=1 and grow=1 one cycle later, score 00->01, busy high 3 cycles.
REQ-030 Bench: head (310,305), move_tick -> no hit (edge exclusive), no pulses; head (300,309) -> hit.
REQ-031 Bench: score 09 then hit -> 10; score 99 then hit -> stays 99, pulses still issued.
REQ-032 Bench: hit, then move_tick with hit again during WAIT1 -> ignored, exactly one create_new_box pulse.
REQ-033 Bench: with FOOD_TIMEOUT_EN and TIMEOUT_TICKS=4, four non-hit ticks -> create_new_box only, grow=0, score unchanged; a hit on the 4th tick -> normal EAT.
REQ-034 Bench: rst asserted in EAT, and game_active dropped in WAIT1 -> IDLE next edge, no further pulses, score 00 after rst / held after game_active drop.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks.
// The TOUT state exists only when FOOD_TIMEOUT_EN is defined.
package snake_pkg;

  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int BOX_SIZE_DEF = 10;

`ifdef FOOD_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EAT   = 3'd1,
    WAIT1 = 3'd2,
    WAIT2 = 3'd3,
    TOUT  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EAT   = 3'd1,
    WAIT1 = 3'd2,
    WAIT2 = 3'd3
  } state_t;
`endif

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter that sticks at 99.
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] q
);

  // Count in BCD, carrying units 9 into tens, saturating at 99.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 8'h00;
    end else if (inc && (q != 8'h99)) begin
      if (q[3:0] == 4'd9) begin
        q[3:0] <= 4'd0;
        q[7:4] <= q[7:4] + 4'd1;
      end else begin
        q[3:0] <= q[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/food_eat_ctrl.sv
// Food-eat controller: detects the snake head entering the food box,
// requests a new box and a body segment, and keeps the BCD score.
// Optional macro FOOD_TIMEOUT_EN adds a move-tick timer that relocates
// an uneaten box after TIMEOUT_TICKS ticks.
module food_eat_ctrl
  import snake_pkg::*;
#(
  parameter int BOX_SIZE      = BOX_SIZE_DEF,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           move_tick,
  input  logic           game_active,
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  input  logic [X_W-1:0] box_x,
  input  logic [Y_W-1:0] box_y,
  output logic           create_new_box,
  output logic           grow,
  output logic [7:0]     score_bcd,
  output logic           busy
);

  localparam logic [X_W:0] BOX_XE = (X_W+1)'(BOX_SIZE);
  localparam logic [Y_W:0] BOX_YE = (Y_W+1)'(BOX_SIZE);

  state_t       state_q;
  state_t       next_state;
  logic         pulse_box;
  logic         pulse_grow;
  logic [X_W:0] x_end;
  logic [Y_W:0] y_end;
  logic         hit;

  // Box far edges are one bit wider so a box near the screen edge cannot wrap.
  assign x_end = {1'b0, box_x} + BOX_XE;
  assign y_end = {1'b0, box_y} + BOX_YE;
  assign hit   = (head_x >= box_x) && ({1'b0, head_x} < x_end) &&
                 (head_y >= box_y) && ({1'b0, head_y} < y_end);

`ifdef FOOD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);

  logic [TMR_W-1:0] timer_q;
  logic             expire;

  assign expire = (timer_q == TMR_W'(TIMEOUT_TICKS - 1));

  // Count non-hit move ticks in IDLE; clear on hit, expiry or a paused game.
  always_ff @(posedge clk) begin
    if (rst || !game_active) begin
      timer_q <= '0;
    end else if ((state_q == IDLE) && move_tick) begin
      if (hit || expire) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end
`else
  // TIMEOUT_TICKS only matters when the timeout feature is built in.
  if (TIMEOUT_TICKS < 1) begin : g_no_timer
  end
`endif

  // Next state and the pulses that the next state implies; a paused game
  // always returns to IDLE quietly.
  always_comb begin
    next_state = state_q;
    pulse_box  = 1'b0;
    pulse_grow = 1'b0;
    case (state_q)
      IDLE: begin
        if (move_tick && hit) begin
          next_state = EAT;
`ifdef FOOD_TIMEOUT_EN
        end else if (move_tick && expire) begin
          next_state = TOUT;
`endif
        end
      end
      EAT:     next_state = WAIT1;
`ifdef FOOD_TIMEOUT_EN
      TOUT:    next_state = WAIT1;
`endif
      WAIT1:   next_state = WAIT2;
      WAIT2:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!game_active) begin
      next_state = IDLE;
    end
    if (next_state == EAT) begin
      pulse_box  = 1'b1;
      pulse_grow = 1'b1;
    end
`ifdef FOOD_TIMEOUT_EN
    if (next_state == TOUT) begin
      pulse_box = 1'b1;
    end
`endif
  end

  // State register with registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      create_new_box <= 1'b0;
      grow           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= next_state;
      create_new_box <= pulse_box;
      grow           <= pulse_grow;
      busy           <= (next_state != IDLE);
    end
  end

  bcd_counter2 u_score (
    .clk (clk),
    .rst (rst),
    .inc (pulse_grow),
    .q   (score_bcd)
  );

endmodule
